// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR pattern sequencer.
package lfsr_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] DEFAULT_TAPS_4 = 4'b1010;
   localparam int         DEFAULT_SEED   = 1;
endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: load has priority over step; the feedback bit enters at bit 0.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS_4
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] r_lfsr;
   logic             w_fb;
   logic [WIDTH-1:0] w_next;

   assign w_fb   = ^(r_lfsr & TAPS);
   assign w_next = {r_lfsr[WIDTH-2:0], w_fb};
   assign q      = r_lfsr;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_lfsr <= WIDTH'(DEFAULT_SEED);
      end else if (load) begin
         r_lfsr <= load_val;
      end else if (step) begin
         r_lfsr <= w_next;
      end
   end
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR sequencer: loads a seed on start, emits len words on a valid/ready stream, then pulses done.
// Optional LFSR_ZERO_SEED_GUARD_EN replaces an all-zero seed with 1 at load time.
module lfsr_seq_ctrl
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS_4,
   parameter int               CNT_W = 8
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] len,
   input  logic             abort,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);
   // Stream handshake: a word transfers on a rising edge where out_valid and out_ready
   // are both high; out_valid never depends on out_ready, and out_data holds while stalled.
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_len_q;
   logic [WIDTH-1:0] r_seed_q;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_done;

   logic             w_hs;
   logic             w_last;
   logic             w_load;
   logic [WIDTH-1:0] w_load_val;

   assign w_hs   = r_out_valid & out_ready;
   assign w_last = (r_cnt == (r_len_q - CNT_ONE));
   assign w_load = (r_state == LOAD);

`ifdef LFSR_ZERO_SEED_GUARD_EN
   assign w_load_val = (r_seed_q == '0) ? WIDTH'(DEFAULT_SEED) : r_seed_q;
`else
   assign w_load_val = r_seed_q;
`endif

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_core (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (w_load),
      .load_val (w_load_val),
      .step     (w_hs),
      .q        (out_data)
   );

   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

   // Outputs are registered alongside the state so they always match the state they belong to.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_len_q     <= '0;
         r_seed_q    <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_seed_q <= seed;
                  r_len_q  <= len;
                  r_busy   <= 1'b1;
                  if (len != '0) begin
                     r_state <= LOAD;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt       <= '0;
                  r_state     <= RUN;
                  r_out_valid <= 1'b1;
               end
            end
            RUN: begin
               if (w_hs) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
               if (abort) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (w_hs && w_last) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
